unum4_fpu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `fpu` instance (unum4 add/sub/mul/div) among `N_REQ` requesters. It accepts one operation at a time and holds `run`, operands and opcode stable until the FPU signals `done`. It then captures the result and accumulated exception flags, returns them to the originating requester, and pulses an FPU clear to re-arm the datapath for the next operation. It sits between requester ports (CPU-side accelerator slots or Versat units) and a single FPU instance.

---
 rtl/unum4_pkg.sv | 51 +++++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/unum4_fpu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_unum4_fpu_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unum4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : unum4_pkg
//  Purpose  : Shared definitions for the unum4 FPU sharing logic: opcode
//             encoding, sequencer state encoding, response flag layout and a
//             flag-accumulation helper.
//  Revision : 1.0 - initial release
// ============================================================================
package unum4_pkg;

    // FPU opcode encoding (passed through to the FPU unchecked)
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RESP    = 3'd3,
        ST_CLEAR   = 3'd4
    } fsm_state_t;

    // Response flag layout: {timeout, div_by_zero, underflow, overflow}
    localparam int FLAGS_W = 4;
    localparam int FLG_OVF = 0;
    localparam int FLG_UDF = 1;
    localparam int FLG_DBZ = 2;
    localparam int FLG_TMO = 3;

    localparam logic [FLAGS_W-1:0] FLAG_TMO_MASK = FLAGS_W'(1) << FLG_TMO;

    // OR the three FPU exception outputs into a sticky accumulator
    function automatic logic [FLAGS_W-1:0] merge_fpu_flags(
        input logic [FLAGS_W-1:0] acc,
        input logic               ovf,
        input logic               udf,
        input logic               dbz
    );
        logic [FLAGS_W-1:0] res;
        res          = acc;
        res[FLG_OVF] = acc[FLG_OVF] | ovf;
        res[FLG_UDF] = acc[FLG_UDF] | udf;
        res[FLG_DBZ] = acc[FLG_DBZ] | dbz;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Grants the first requester
//             found searching upward from last+1, wrapping modulo N.
//  Ports    : req       - request vector
//             last      - index of the previous winner
//             grant     - one-hot grant (all zero when nothing requests)
//             grant_idx - binary index of the granted requester
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N       = 4,
    localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]       req,
    input  logic [c_IDX_W-1:0] last,
    output logic [N-1:0]       grant,
    output logic [c_IDX_W-1:0] grant_idx
);

    logic [N-1:0] w_masked;
    logic [N-1:0] w_pool;

    // Requests strictly above 'last' take priority; if none, fall back to the
    // full vector, which is the wrap-around half of the search.
    always_comb begin
        w_masked = '0;
        for (int i = 0; i < N; i++) begin
            w_masked[i] = req[i] && (c_IDX_W'(i) > last);
        end
        w_pool = (|w_masked) ? w_masked : req;
    end

    // Lowest set bit of the pool wins
    always_comb begin
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_pool[i]) begin
                grant_idx = c_IDX_W'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = w_pool[i] && (grant_idx == c_IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/unum4_fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unum4_fpu_arbiter
//  Purpose  : Shares a single unum4 FPU among N_REQ requesters. One operation
//             at a time is accepted round-robin, issued to the FPU with stable
//             operands until done (or a timeout), its result and accumulated
//             exception flags returned to the originating requester, and the
//             FPU re-armed with a one-cycle clear pulse.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             req_valid/ready/a/b/op    - packed requester ports
//             resp_valid/data/flags     - one-hot result strobe + payload
//             busy                      - high whenever not IDLE
//             fpu_run/in0/in1/op/clr    - FPU drive
//             fpu_out0/done/overflow/
//             underflow/div_by_zero     - FPU status
//  Revision : 1.0 - initial release
// ============================================================================
module unum4_fpu_arbiter
    import unum4_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 32,
    parameter int OPCODE_W = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    input  logic [N_REQ*OPCODE_W-1:0] req_op,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic [3:0]                resp_flags,
    output logic                      busy,
    output logic                      fpu_run,
    output logic [DATA_W-1:0]         fpu_in0,
    output logic [DATA_W-1:0]         fpu_in1,
    output logic [OPCODE_W-1:0]       fpu_op,
    output logic                      fpu_clr,
    input  logic [DATA_W-1:0]         fpu_out0,
    input  logic                      fpu_done,
    input  logic                      fpu_overflow,
    input  logic                      fpu_underflow,
    input  logic                      fpu_div_by_zero
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CNT_W = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    fsm_state_t           r_state;
    logic [c_IDX_W-1:0]   r_last;
    logic [N_REQ-1:0]     r_grant;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [OPCODE_W-1:0]  r_op;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [FLAGS_W-1:0]   r_flags;
    logic [DATA_W-1:0]    r_resp_data;
    logic [N_REQ-1:0]     r_resp_valid;
    logic                 r_fpu_run;
    logic                 r_fpu_clr;

    logic [N_REQ-1:0]     w_grant;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic                 w_idle;
    logic                 w_accept;
    logic [FLAGS_W-1:0]   w_flags_next;

    logic [DATA_W-1:0]    w_a_arr  [N_REQ];
    logic [DATA_W-1:0]    w_b_arr  [N_REQ];
    logic [OPCODE_W-1:0]  w_op_arr [N_REQ];

    // Unpack the flat requester buses so the winner can be picked by index
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_a_arr[g]  = req_a[g*DATA_W +: DATA_W];
            assign w_b_arr[g]  = req_b[g*DATA_W +: DATA_W];
            assign w_op_arr[g] = req_op[g*OPCODE_W +: OPCODE_W];
        end
    endgenerate

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .last      (r_last),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept     = w_idle && (|(req_valid & w_grant));
    assign w_flags_next = merge_fpu_flags(r_flags, fpu_overflow, fpu_underflow,
                                          fpu_div_by_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last       <= c_IDX_W'(N_REQ - 1);
            r_grant      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_cnt        <= '0;
            r_flags      <= '0;
            r_resp_data  <= '0;
            r_resp_valid <= '0;
            r_fpu_run    <= 1'b0;
            r_fpu_clr    <= 1'b0;
        end else begin
            // Strobes default low; the state that needs them sets them
            r_resp_valid <= '0;
            r_fpu_clr    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a       <= w_a_arr[w_grant_idx];
                        r_b       <= w_b_arr[w_grant_idx];
                        r_op      <= w_op_arr[w_grant_idx];
                        r_grant   <= w_grant;
                        r_last    <= w_grant_idx;
                        r_flags   <= '0;
                        r_cnt     <= '0;
                        r_fpu_run <= 1'b1;
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // done is checked first so it wins over the terminal count
                    if (fpu_done) begin
                        r_flags   <= w_flags_next;
                        r_fpu_run <= 1'b0;
                        r_state   <= ST_CAPTURE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_flags      <= w_flags_next | FLAG_TMO_MASK;
                        r_resp_data  <= '0;
                        r_fpu_run    <= 1'b0;
                        r_resp_valid <= r_grant;
                        r_state      <= ST_RESP;
                    end else begin
                        r_flags <= w_flags_next;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // out0 becomes valid one cycle after done
                    r_resp_data  <= fpu_out0;
                    r_flags      <= w_flags_next;
                    r_resp_valid <= r_grant;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    r_fpu_clr <= 1'b1;
                    r_state   <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_idle ? w_grant : '0;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_flags = r_flags;
    assign busy       = !w_idle;
    assign fpu_run    = r_fpu_run;
    assign fpu_in0    = r_a;
    assign fpu_in1    = r_b;
    assign fpu_op     = r_op;
    assign fpu_clr    = r_fpu_clr;

endmodule
`default_nettype wire

// File: tb/tb_unum4_fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unum4_fpu_arbiter
//  Purpose  : Self-checking bench for unum4_fpu_arbiter with a model FPU
//             (done after 7 run cycles, out0 = in0 + in1 one cycle later).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unum4_fpu_arbiter;
    import unum4_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int OW = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*OW-1:0] req_op;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic [3:0]      resp_flags;
    logic            busy;
    logic            fpu_run;
    logic [DW-1:0]   fpu_in0;
    logic [DW-1:0]   fpu_in1;
    logic [OW-1:0]   fpu_op;
    logic            fpu_clr;
    logic [DW-1:0]   fpu_out0;
    logic            fpu_done;
    logic            fpu_overflow;
    logic            fpu_underflow;
    logic            fpu_div_by_zero;

    unum4_fpu_arbiter #(
        .N_REQ(N), .DATA_W(DW), .OPCODE_W(OW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
        .busy(busy),
        .fpu_run(fpu_run), .fpu_in0(fpu_in0), .fpu_in1(fpu_in1), .fpu_op(fpu_op),
        .fpu_clr(fpu_clr), .fpu_out0(fpu_out0), .fpu_done(fpu_done),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .fpu_div_by_zero(fpu_div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model FPU ----------------
    bit       m_hang = 1'b0;
    int       m_cnt  = 0;
    always @(posedge clk) begin
        if (rst || fpu_clr) begin
            m_cnt    <= 0;
            fpu_done <= 1'b0;
        end else begin
            if (fpu_run && !fpu_done && !m_hang) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt == 6) fpu_done <= 1'b1;
            end
            if (fpu_done) fpu_out0 <= fpu_in0 + fpu_in1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          port;
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    exp_t        sb_q[$];
    int          grant_q[$];
    logic [3:0]  exp_flags = 4'b0000;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          resp_cyc = -1;
    int          clr_cyc  = -1;
    exp_t        m_e;
    exp_t        m_got;
    int          m_p;

    always @(negedge clk) begin
        // handshake: push the expected response
        if (|(req_valid & req_ready)) begin
            m_p = 0;
            for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) m_p = i;
            m_e.port  = m_p;
            m_e.data  = m_hang ? 32'd0 : (req_a[m_p*DW +: DW] + req_b[m_p*DW +: DW]);
            m_e.flags = m_hang ? 4'b1000 : exp_flags;
            sb_q.push_back(m_e);
            grant_q.push_back(m_p);
        end
        // response: pop and compare
        if (|resp_valid) begin
            resp_cyc = cyc;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: resp_valid=%b with no outstanding request", resp_valid);
            end else begin
                m_got = sb_q.pop_front();
                if (resp_valid !== (4'b0001 << m_got.port)) begin
                    n_bad++;
                    $display("FAIL resp_port: got resp_valid=%b want %b", resp_valid, 4'b0001 << m_got.port);
                end
                n_cmp++;
                if (resp_data !== m_got.data) begin
                    n_bad++;
                    $display("FAIL resp_data: got %0d want %0d", resp_data, m_got.data);
                end
                n_cmp++;
                if (resp_flags !== m_got.flags) begin
                    n_bad++;
                    $display("FAIL resp_flags: got %b want %b", resp_flags, m_got.flags);
                end
            end
        end
        if (fpu_clr) clr_cyc = cyc;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        req_a[p*DW +: DW]  = a;
        req_b[p*DW +: DW]  = b;
        req_op[p*OW +: OW] = op;
        req_valid[p]       = 1'b1;
    endtask

    task automatic wait_grant(input int p, output int t, output bit ok);
        ok = 1'b0;
        t  = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_valid[p] && req_ready[p]) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++;
        if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        n_cmp++;
        if (resp_data !== 32'd0 || resp_flags !== 4'd0) begin
            n_bad++; $display("FAIL reset_resp: got data=%0h flags=%b want 0/0000", resp_data, resp_flags);
        end
        n_cmp++;
        if ({fpu_run, fpu_clr, busy} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: got run,clr,busy=%b want 000", {fpu_run, fpu_clr, busy});
        end
        n_cmp++;
        if ({fpu_in0, fpu_in1, fpu_op} !== '0) begin
            n_bad++; $display("FAIL reset_fpu_in: got in0=%0h in1=%0h op=%0d want 0", fpu_in0, fpu_in1, fpu_op);
        end
    endtask

    task automatic test_single();
        int t, c0;
        bit ok;
        exp_flags = 4'b0000;
        tick();
        c0 = cyc;
        set_req(2, 32'd3, 32'd5, OP_ADD);
        wait_grant(2, t, ok);
        n_cmp++;
        if (!ok || t != c0 || req_ready !== 4'b0100) begin
            n_bad++; $display("FAIL single_grant: got ready=%b at cyc %0d want 0100 at %0d", req_ready, t, c0);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (fpu_run !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL single_run: got run=%b busy=%b at T+1 want 1/1", fpu_run, busy);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || resp_cyc != t + 10) begin
            n_bad++; $display("FAIL single_resp_time: got cyc %0d want %0d", resp_cyc, t + 10);
        end
        n_cmp++;
        if (clr_cyc != t + 11) begin
            n_bad++; $display("FAIL single_clr_time: got cyc %0d want %0d", clr_cyc, t + 11);
        end
    endtask

    task automatic test_operand_hold();
        int t;
        bit ok;
        tick();
        set_req(1, 32'd100, 32'd23, OP_MUL);
        wait_grant(1, t, ok);
        tick();
        req_valid = '0;
        req_a[1*DW +: DW] = 32'hDEAD_BEEF;
        req_b[1*DW +: DW] = 32'h1234_5678;
        req_op[1*OW +: OW] = OP_SUB;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_cmp++;
            if (fpu_in0 !== 32'd100 || fpu_in1 !== 32'd23 || fpu_op !== OP_MUL) begin
                n_bad++;
                $display("FAIL operand_hold: cyc T+%0d got in0=%0d in1=%0d op=%0d want 100/23/3",
                         k + 1, fpu_in0, fpu_in1, fpu_op);
            end
        end
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL operand_hold_done: got busy=%b want idle", busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        exp_flags = 4'b0000;
        do_reset();
        grant_q.delete();
        for (int i = 0; i < N; i++) set_req(i, 32'(i * 16 + 1), 32'(i + 2), OP_ADD);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (grant_q.size() >= 5) break;
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (grant_q.size() < 5) begin
            n_bad++; $display("FAIL rr_count: got %0d grants want 5", grant_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (grant_q[k] != k % N) begin
                    n_bad++; $display("FAIL rr_order: grant %0d got port %0d want %0d", k, grant_q[k], k % N);
                end
            end
        end
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rr_done: got %0d outstanding want 0", sb_q.size()); end
    endtask

    task automatic test_div_by_zero();
        int t;
        bit ok;
        exp_flags = 4'b0100;
        tick();
        set_req(1, 32'd7, 32'd9, OP_DIV);
        wait_grant(1, t, ok);
        tick();
        req_valid = '0;
        tick();
        fpu_div_by_zero = 1'b1;
        tick();
        fpu_div_by_zero = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fpu_op !== OP_DIV) begin n_bad++; $display("FAIL dbz_op: got %0d want 2", fpu_op); end
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL dbz_done: got busy=%b want idle", busy); end
        exp_flags = 4'b0000;
    endtask

    task automatic test_timeout();
        int t;
        bit ok;
        m_hang = 1'b1;
        tick();
        set_req(3, 32'd1, 32'd2, OP_ADD);
        wait_grant(3, t, ok);
        tick();
        req_valid = '0;
        wait_done(ok);
        n_cmp++;
        if (!ok || resp_cyc != t + 1 + TO) begin
            n_bad++; $display("FAIL timeout_resp_time: got cyc %0d want %0d", resp_cyc, t + 1 + TO);
        end
        n_cmp++;
        if (clr_cyc != t + 2 + TO) begin
            n_bad++; $display("FAIL timeout_clr_time: got cyc %0d want %0d", clr_cyc, t + 2 + TO);
        end
        m_hang = 1'b0;
        tick();
        set_req(0, 32'd40, 32'd2, OP_ADD);
        wait_grant(0, t, ok);
        tick();
        req_valid = '0;
        wait_done(ok);
        n_cmp++;
        if (!ok || resp_cyc != t + 10) begin
            n_bad++; $display("FAIL after_timeout_resp_time: got cyc %0d want %0d", resp_cyc, t + 10);
        end
    endtask

    task automatic test_rst_mid();
        int t;
        bit ok;
        tick();
        set_req(2, 32'd5, 32'd6, OP_ADD);
        wait_grant(2, t, ok);
        tick();
        req_valid = '0;
        tick();
        tick();
        resp_cyc = -1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fpu_run !== 1'b0 || busy !== 1'b0 || resp_valid !== 4'b0000) begin
            n_bad++; $display("FAIL rst_mid_state: got run=%b busy=%b resp_valid=%b want 0/0/0000",
                              fpu_run, busy, resp_valid);
        end
        sb_q.delete();
        repeat (12) @(negedge clk);
        n_cmp++;
        if (resp_cyc != -1) begin
            n_bad++; $display("FAIL rst_mid_noresp: got response at cyc %0d want none", resp_cyc);
        end
        grant_q.delete();
        tick();
        set_req(0, 32'd11, 32'd22, OP_ADD);
        set_req(3, 32'd33, 32'd44, OP_ADD);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (grant_q.size() >= 1) break;
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (grant_q.size() < 1 || grant_q[0] != 0) begin
            n_bad++; $display("FAIL rst_mid_first_grant: got port %0d want 0",
                              (grant_q.size() > 0) ? grant_q[0] : -1);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rst_mid_done: got busy=%b want idle", busy); end
    endtask

    initial begin
        rst             = 1'b1;
        req_valid       = '0;
        req_a           = '0;
        req_b           = '0;
        req_op          = '0;
        fpu_overflow    = 1'b0;
        fpu_underflow   = 1'b0;
        fpu_div_by_zero = 1'b0;
        fpu_done        = 1'b0;
        fpu_out0        = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_operand_hold();
        test_round_robin();
        test_div_by_zero();
        test_timeout();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
